// File: rtl/masked_sbox_layer_pipe.sv
// Masked SKINNY S8 layer: N_SBOX masked S-box cores in parallel behind a randomness-gated input
// handshake, with a valid pipeline, zeroed idle outputs, an in-flight count and a starvation flag.
module masked_sbox_layer_pipe #(
  parameter int STATE_W  = 64,
  parameter int SBOX_W   = 8,   // the core is the 8-bit SKINNY S8; SBOX_LAT supported range 1..4
  parameter int NSHARES  = 3,
  parameter int RAND_W   = 144,
  parameter int ROT_STEP = 9,
  parameter int SBOX_LAT = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NSHARES*STATE_W-1:0]       in_shares,
  input  logic                             rand_valid,
  input  logic [RAND_W-1:0]                rand_i,
  output logic                             rand_ack,
  output logic                             out_valid,
  output logic [NSHARES*STATE_W-1:0]       out_shares,
  output logic [$clog2(SBOX_LAT+3)-1:0]    in_flight,
  output logic                             starve,
  input  logic                             starve_clr
);

  localparam int N_SBOX = STATE_W / SBOX_W;
  localparam int NR     = NSHARES * (NSHARES - 1) / 2;  // fresh bits per masked AND
  localparam int CR_W   = 8 * NR;                       // 4 rounds x 2 ANDs per S8
  localparam int SH_W   = NSHARES * SBOX_W;
  localparam int SW     = NSHARES * STATE_W;
  localparam int CNT_W  = $clog2(SBOX_LAT + 3);

  function automatic logic [7:0] perm8(input logic [7:0] x);
    return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
  endfunction

  function automatic logic [7:0] swap8(input logic [7:0] x);
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

  function automatic logic [NSHARES-1:0] dom_and(input logic [NSHARES-1:0] a,
                                                 input logic [NSHARES-1:0] b,
                                                 input logic [NR-1:0]      z);
    logic [NSHARES-1:0] c;
    int p;
    c = a & b;
    p = 0;
    for (int i = 0; i < NSHARES; i++) begin
      for (int j = i + 1; j < NSHARES; j++) begin
        c[i] = c[i] ^ (a[i] & b[j]) ^ z[p];
        c[j] = c[j] ^ (a[j] & b[i]) ^ z[p];
        p = p + 1;
      end
    end
    return c;
  endfunction

  // One S8 round on shared data; NOR(a,b) = ~a & ~b, and flipping share 0 complements the value.
  function automatic logic [SH_W-1:0] sb_layer(input logic [SH_W-1:0] x,
                                               input logic [2*NR-1:0] r,
                                               input logic            last);
    logic [NSHARES-1:0] a0, b0, a1, b1, c0, c1;
    logic [7:0] t;
    logic [SH_W-1:0] y;
    for (int s = 0; s < NSHARES; s++) begin
      a0[s] = x[s*SBOX_W + 7];
      b0[s] = x[s*SBOX_W + 6];
      a1[s] = x[s*SBOX_W + 3];
      b1[s] = x[s*SBOX_W + 2];
    end
    a0[0] = ~a0[0];
    b0[0] = ~b0[0];
    a1[0] = ~a1[0];
    b1[0] = ~b1[0];
    c0 = dom_and(a0, b0, r[NR-1:0]);
    c1 = dom_and(a1, b1, r[2*NR-1:NR]);
    for (int s = 0; s < NSHARES; s++) begin
      t = x[s*SBOX_W +: SBOX_W];
      t[4] = t[4] ^ c0[s];
      t[0] = t[0] ^ c1[s];
      y[s*SBOX_W +: SBOX_W] = last ? swap8(t) : perm8(t);
    end
    return y;
  endfunction

  // Rotate left by amt, then fold every bit into the core's randomness width.
  function automatic logic [CR_W-1:0] fold_rot(input logic [RAND_W-1:0] r, input int amt);
    logic [CR_W-1:0] f;
    f = '0;
    for (int b = 0; b < RAND_W; b++) begin
      f[b % CR_W] = f[b % CR_W] ^ r[(b + RAND_W - amt) % RAND_W];
    end
    return f;
  endfunction

  logic                   accept;
  logic [SW-1:0]          s0_sh_q;
  logic [RAND_W-1:0]      s0_rnd_q;
  logic [SW-1:0]          core_all;
  logic [SBOX_LAT:0]      vld_q;
  logic                   out_valid_q;
  logic [SW-1:0]          out_shares_q;
  logic [CNT_W-1:0]       in_flight_q, in_flight_d;
  logic                   starve_q, starve_d;

  assign accept   = in_valid & rand_valid;
  assign rand_ack = accept;
  assign in_ready = rand_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_sh_q  <= '0;
      s0_rnd_q <= '0;
    end else begin
      s0_sh_q  <= accept ? in_shares : '0;
      s0_rnd_q <= accept ? rand_i : '0;
    end
  end

  for (genvar gi = 0; gi < N_SBOX; gi++) begin : g_sbox
    logic [4:0][SH_W-1:0] xs;
    logic [CR_W-1:0]      rf;
    logic [SH_W-1:0]      core_q;

    assign rf = fold_rot(s0_rnd_q, (gi * ROT_STEP) % RAND_W);

    for (genvar gs = 0; gs < NSHARES; gs++) begin : g_sh
      assign xs[0][gs*SBOX_W +: SBOX_W] = s0_sh_q[gs*STATE_W + gi*SBOX_W +: SBOX_W];
      assign core_all[gs*STATE_W + gi*SBOX_W +: SBOX_W] = core_q[gs*SBOX_W +: SBOX_W];
    end

    for (genvar gl = 0; gl < 4; gl++) begin : g_lay
      localparam int D = (gl < SBOX_LAT - 1) ? gl : SBOX_LAT - 1;
      logic [2*NR-1:0] ri;
      logic [SH_W-1:0] y;

      // Randomness for this round is delayed to match the register stages ahead of it.
      if (D == 0) begin : g_r0
        assign ri = rf[gl*2*NR +: 2*NR];
      end else begin : g_rd
        logic [D-1:0][2*NR-1:0] rd_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            rd_q <= '0;
          end else begin
            rd_q[0] <= rf[gl*2*NR +: 2*NR];
            for (int j = 1; j < D; j++) rd_q[j] <= rd_q[j-1];
          end
        end
        assign ri = rd_q[D-1];
      end

      assign y = sb_layer(xs[gl], ri, gl == 3);

      if (gl < SBOX_LAT - 1) begin : g_reg
        logic [SH_W-1:0] x_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) x_q <= '0;
          else        x_q <= y;
        end
        assign xs[gl+1] = x_q;
      end else begin : g_comb
        assign xs[gl+1] = y;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) core_q <= '0;
      else        core_q <= xs[4];
    end
  end

  always_comb begin
    in_flight_d = in_flight_q + CNT_W'(accept) - CNT_W'(out_valid_q);
    starve_d    = (in_valid & ~rand_valid) | (starve_q & ~starve_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      out_valid_q  <= 1'b0;
      out_shares_q <= '0;
      in_flight_q  <= '0;
      starve_q     <= 1'b0;
    end else begin
      vld_q        <= {vld_q[SBOX_LAT-1:0], accept};
      out_valid_q  <= vld_q[SBOX_LAT];
      out_shares_q <= vld_q[SBOX_LAT] ? core_all : '0;
      in_flight_q  <= in_flight_d;
      starve_q     <= starve_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_shares = out_shares_q;
  assign in_flight  = in_flight_q;
  assign starve     = starve_q;

endmodule

// File: tb/tb_masked_sbox_layer_pipe.sv
// Randomized bench for masked_sbox_layer_pipe against a byte-wise S8 reference and an
// output-time scoreboard.
module tb_masked_sbox_layer_pipe;

  localparam int STATE_W  = 64;
  localparam int NSHARES  = 3;
  localparam int RAND_W   = 144;
  localparam int SBOX_LAT = 3;
  localparam int SW       = NSHARES * STATE_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, rand_valid, rand_ack;
  logic [SW-1:0]     in_shares, out_shares;
  logic [RAND_W-1:0] rand_i;
  logic              out_valid, starve, starve_clr;
  logic [2:0]        in_flight;

  always #5 clk = ~clk;

  masked_sbox_layer_pipe #(
    .STATE_W(STATE_W), .SBOX_W(8), .NSHARES(NSHARES), .RAND_W(RAND_W),
    .ROT_STEP(9), .SBOX_LAT(SBOX_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_shares(in_shares), .rand_valid(rand_valid), .rand_i(rand_i), .rand_ack(rand_ack),
    .out_valid(out_valid), .out_shares(out_shares), .in_flight(in_flight),
    .starve(starve), .starve_clr(starve_clr)
  );

  typedef struct {
    int                 due;
    logic [STATE_W-1:0] val;
  } exp_t;

  exp_t               expq[$];
  logic [SW-1:0]      cap[$];
  int                 errors = 0;
  int                 checks = 0;
  int                 pcount = 0;
  int                 pulses = 0;
  int                 max_inflight = 0;
  logic               starve_exp = 1'b0;
  logic [STATE_W-1:0] last_rec = '0;

  task automatic check_eq(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SKINNY-128 S8 written as repeated mix / bit-permute rounds.
  function automatic logic [7:0] s8(input logic [7:0] xin);
    logic [7:0] x;
    x = xin;
    for (int i = 0; i < 4; i++) begin
      x = x ^ ((~(((x >> 1) | x) >> 2)) & 8'h11);
      if (i < 3)
        x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
            ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
    end
    return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
  endfunction

  function automatic logic [STATE_W-1:0] layer_ref(input logic [STATE_W-1:0] v);
    logic [STATE_W-1:0] r;
    for (int b = 0; b < STATE_W / 8; b++) r[b*8 +: 8] = s8(v[b*8 +: 8]);
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] recomb(input logic [SW-1:0] sh);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int s = 0; s < NSHARES; s++) r = r ^ sh[s*STATE_W +: STATE_W];
    return r;
  endfunction

  function automatic logic [SW-1:0] make_shares(input logic [STATE_W-1:0] v);
    logic [SW-1:0]      sh;
    logic [STATE_W-1:0] acc;
    acc = v;
    for (int s = 0; s < NSHARES - 1; s++) begin
      sh[s*STATE_W +: STATE_W] = {$urandom(), $urandom()};
      acc = acc ^ sh[s*STATE_W +: STATE_W];
    end
    sh[(NSHARES-1)*STATE_W +: STATE_W] = acc;
    return sh;
  endfunction

  function automatic logic [RAND_W-1:0] rnd_word();
    logic [159:0] t;
    for (int i = 0; i < 5; i++) t = {t[127:0], $urandom()};
    return t[RAND_W-1:0];
  endfunction

  task automatic sample_outputs();
    exp_t h;
    logic due;
    due = (expq.size() > 0) && (expq[0].due == pcount);
    check_eq("out_valid", out_valid, due);
    check_eq("in_flight", in_flight, expq.size());
    check_eq("starve", starve, starve_exp);
    if (int'(in_flight) > max_inflight) max_inflight = int'(in_flight);
    if (due) begin
      h = expq.pop_front();
      if (out_valid) begin
        pulses++;
        last_rec = recomb(out_shares);
        check_eq("out_recomb", last_rec, h.val);
        cap.push_back(out_shares);
      end
    end else begin
      check_eq("idle_zero", out_shares, '0);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic tick();
    logic acc;
    #1;
    acc = in_valid && rand_valid;
    check_eq("rand_ack", rand_ack, acc);
    check_eq("in_ready", in_ready, rand_valid);
    @(posedge clk);
    pcount++;
    if (acc) expq.push_back('{pcount + SBOX_LAT + 1, layer_ref(recomb(in_shares))});
    if (in_valid && !rand_valid) starve_exp = 1'b1;
    else if (starve_clr)         starve_exp = 1'b0;
    @(negedge clk);
    sample_outputs();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [SW-1:0]     sh;
    logic [RAND_W-1:0] r1;

    rst_n = 1'b0; in_valid = 1'b0; rand_valid = 1'b0; starve_clr = 1'b0;
    in_shares = '0; rand_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_shares", out_shares, '0);
    check_eq("rst_in_flight", in_flight, 3'd0);
    check_eq("rst_starve", starve, 1'b0);
    rst_n = 1'b1;

    // zero-valued block: S8(0x00) = 0x65 in every byte
    in_valid = 1'b1; rand_valid = 1'b1;
    in_shares = make_shares('0); rand_i = rnd_word();
    tick();
    idle(6);
    check_eq("s8_zero", last_rec, 64'h6565656565656565);

    // eight back-to-back blocks
    pulses = 0; max_inflight = 0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'(i);
      in_valid = 1'b1; rand_valid = 1'b1;
      in_shares = make_shares({8{b}}); rand_i = rnd_word();
      tick();
    end
    idle(7);
    check_eq("b2b_pulses", pulses, 8);
    check_eq("inflight_peak", max_inflight, 5);
    check_eq("inflight_drained", in_flight, 3'd0);

    // starvation: two cycles without randomness, clear, then clear colliding with a new event
    in_valid = 1'b1; rand_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b0; starve_clr = 1'b1;
    tick();
    in_valid = 1'b1; rand_valid = 1'b0; starve_clr = 1'b1;
    tick();
    in_valid = 1'b0; starve_clr = 1'b1;
    tick();
    starve_clr = 1'b0;

    // same sharing, randomness differing in one bit
    cap.delete();
    sh = make_shares({$urandom(), $urandom()});
    r1 = rnd_word();
    in_valid = 1'b1; rand_valid = 1'b1; in_shares = sh; rand_i = r1;
    tick();
    rand_i = r1 ^ {{(RAND_W-1){1'b0}}, 1'b1};
    tick();
    idle(6);
    check_eq("mask_caps", cap.size(), 2);
    if (cap.size() == 2) begin
      check_eq("mask_differs", cap[0] != cap[1], 1'b1);
      check_eq("mask_recomb_eq", recomb(cap[0]), recomb(cap[1]));
    end

    // reset two cycles after an accept discards the block
    in_valid = 1'b1; rand_valid = 1'b1;
    in_shares = make_shares({$urandom(), $urandom()}); rand_i = rnd_word();
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_out_shares", out_shares, '0);
    check_eq("arst_in_flight", in_flight, 3'd0);
    expq.delete();
    starve_exp = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(8);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      rand_valid = ($urandom_range(0, 3) != 0);
      starve_clr = ($urandom_range(0, 7) == 0);
      in_shares  = make_shares({$urandom(), $urandom()});
      rand_i     = rnd_word();
      tick();
    end
    starve_clr = 1'b0;
    idle(8);
    check_eq("final_in_flight", in_flight, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
